// File: rtl/hex_display_ctrl_if.sv
// Register bus between the system interconnect and hex_display_ctrl.
// The master drives address/strobes/data; the slave returns registered readdata.
interface hex_display_ctrl_if;
  logic [5:0] address;
  logic       write;
  logic [7:0] writedata;
  logic       read;
  logic [7:0] readdata;

  modport master (
    output address, write, writedata, read,
    input  readdata
  );

  modport slave (
    input  address, write, writedata, read,
    output readdata
  );
endinterface

// File: rtl/hex_display_ctrl.sv
// Seven-segment display controller: per-digit hex/raw registers, prescaled blink,
// and a scrolling message buffer that is only built when HEX_SCROLL_EN is defined.
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_DEPTH  = 16,
  parameter int TICK_DIV   = 5000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  hex_display_ctrl_if.slave       bus,
  output logic [7*NUM_DIGITS-1:0] seg
);

  localparam int CNT_W  = $clog2(TICK_DIV);
  localparam int DIG_IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [7:0]        digit_reg [NUM_DIGITS];
  logic              en;
  logic              blink;
  logic              phase;
  logic [7:0]        mask;
  logic [CNT_W-1:0]  cnt;
  logic              tick;

  logic              digit_sel;
  logic              ctrl_sel;
  logic              mask_sel;
  logic [DIG_IW-1:0] digit_idx;

  logic [7:0]              rd_value;
  logic [6:0]              lit;
  logic [7*NUM_DIGITS-1:0] seg_next;

  // Entry format shared by digit and message registers: bit7 selects raw segments.
  function automatic logic [6:0] decode_entry(input logic [7:0] entry);
    logic [6:0] glyph;
    case (entry[3:0])
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
    return entry[7] ? entry[6:0] : glyph;
  endfunction

  assign digit_sel = (bus.address[5:4] == 2'b00) && (bus.address[3:0] < 4'(NUM_DIGITS));
  assign ctrl_sel  = (bus.address == 6'h10);
  assign mask_sel  = (bus.address == 6'h11);
  assign digit_idx = bus.address[DIG_IW-1:0];
  assign tick      = (cnt == CNT_MAX);

`ifdef HEX_SCROLL_EN
  localparam int MSG_IW = $clog2(MSG_DEPTH);
  localparam int POS_W  = $clog2(MSG_DEPTH + 1);
  localparam int KW     = POS_W + 1;

  logic [7:0]        msg_reg [MSG_DEPTH];
  logic [POS_W-1:0]  len;
  logic [POS_W-1:0]  pos;
  logic [POS_W-1:0]  pos_next;
  logic [POS_W-1:0]  len_clamped;
  logic              scroll;
  logic              wrap;
  logic              done;
  logic              len_sel;
  logic              msg_sel;
  logic              advance;
  logic              pos_clear;
  logic [KW-1:0]     k;

  assign len_sel = (bus.address == 6'h12);
  assign msg_sel = (bus.address[5:4] == 2'b10) && ({2'b00, bus.address[3:0]} < 6'(MSG_DEPTH));

  assign len_clamped = (bus.writedata == 8'h00)             ? POS_W'(1) :
                       (bus.writedata > 8'(MSG_DEPTH))      ? POS_W'(MSG_DEPTH) :
                                                              bus.writedata[POS_W-1:0];

  // Without WRAP the pointer parks at LEN; with WRAP it folds back from LEN-1.
  assign advance   = tick && en && scroll && (wrap || (pos < len));
  assign pos_next  = (wrap && (pos >= len - POS_W'(1))) ? '0 : pos + POS_W'(1);
  assign pos_clear = bus.write && (len_sel || (ctrl_sel && bus.writedata[2] && !scroll));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MSG_DEPTH; i++) msg_reg[i] <= '0;
      len    <= POS_W'(1);
      pos    <= '0;
      scroll <= 1'b0;
      wrap   <= 1'b0;
      done   <= 1'b0;
    end else begin
      if (bus.write && msg_sel) msg_reg[bus.address[MSG_IW-1:0]] <= bus.writedata;
      if (bus.write && len_sel) len <= len_clamped;
      if (bus.write && ctrl_sel) begin
        scroll <= bus.writedata[2];
        wrap   <= bus.writedata[3];
      end
      if (pos_clear) pos <= '0;
      else if (advance) pos <= pos_next;
      // A CTRL write always wins over a DONE set landing on the same edge.
      if (bus.write && ctrl_sel) done <= 1'b0;
      else if (advance && !wrap && (pos_next == len)) done <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_reg[i] <= '0;
      en    <= 1'b0;
      blink <= 1'b0;
      mask  <= '0;
    end else if (bus.write) begin
      if (digit_sel) digit_reg[digit_idx] <= bus.writedata;
      if (ctrl_sel) begin
        en    <= bus.writedata[0];
        blink <= bus.writedata[1];
      end
      if (mask_sel) mask <= bus.writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    rd_value = '0;
    if (digit_sel) rd_value = digit_reg[digit_idx];
    if (mask_sel)  rd_value = mask;
`ifdef HEX_SCROLL_EN
    if (ctrl_sel)  rd_value = {done, 3'b000, wrap, scroll, blink, en};
    if (len_sel)   rd_value = 8'(len);
    if (msg_sel)   rd_value = msg_reg[bus.address[MSG_IW-1:0]];
`else
    if (ctrl_sel)  rd_value = {6'b000000, blink, en};
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) bus.readdata <= '0;
    else if (bus.read) bus.readdata <= rd_value;
  end

  // Per-digit source: blank when disabled, else message window or digit register, then blink.
  always_comb begin
    seg_next = '0;
    lit      = '0;
`ifdef HEX_SCROLL_EN
    k        = '0;
`endif
    for (int d = 0; d < NUM_DIGITS; d++) begin
      lit = '0;
      if (en) begin
`ifdef HEX_SCROLL_EN
        if (scroll) begin
          k = {1'b0, pos} + KW'(NUM_DIGITS - 1 - d);
          if (wrap) k = k % {1'b0, len};
          if (wrap || (k < {1'b0, len})) lit = decode_entry(msg_reg[k[MSG_IW-1:0]]);
        end else
`endif
        lit = decode_entry(digit_reg[d]);
        if (blink && phase && mask[d]) lit = '0;
      end
      seg_next[7*d +: 7] = lit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) seg <= {(7*NUM_DIGITS){ACTIVE_LOW}};
    else seg <= ACTIVE_LOW ? ~seg_next : seg_next;
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomised bench for hex_display_ctrl against a spec-level reference model.
// Scroll scenarios are included when HEX_SCROLL_EN is defined.
module tb_hex_display_ctrl;
  localparam int ND = 6;
  localparam int MD = 16;
  localparam int TD = 4;
  localparam logic [7*ND-1:0] ALL_BLANK = 42'h3FF_FFFF_FFFF;
  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic clk = 1'b0;
  logic reset;
  logic [7*ND-1:0] seg;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hex_display_ctrl_if bus ();

  hex_display_ctrl #(.NUM_DIGITS(ND), .MSG_DEPTH(MD), .TICK_DIV(TD), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus), .seg(seg)
  );

  // Reference model state: spec-visible registers plus an edge count since reset.
  logic [7:0] m_digit [ND];
  logic [7:0] m_msg [MD];
  logic [7:0] m_mask;
  logic m_en, m_blink, m_scroll, m_wrap, m_done, m_phase;
  int m_len, m_pos, m_edges;
  logic [7*ND-1:0] exp_seg;
  logic [7:0] exp_rd;

  function automatic logic [6:0] ref_entry(input logic [7:0] e);
    return e[7] ? e[6:0] : GLYPH[e[3:0]];
  endfunction

  function automatic logic [7*ND-1:0] model_seg();
    logic [7*ND-1:0] r;
    logic [6:0] l;
    int k;
    r = '1;
    for (int d = 0; d < ND; d++) begin
      l = '0;
      if (m_en) begin
`ifdef HEX_SCROLL_EN
        if (m_scroll) begin
          k = m_pos + (ND - 1 - d);
          if (m_wrap) l = ref_entry(m_msg[k % m_len]);
          else if (k < m_len) l = ref_entry(m_msg[k]);
        end else l = ref_entry(m_digit[d]);
`else
        l = ref_entry(m_digit[d]);
`endif
        if (m_blink && m_phase && m_mask[d]) l = '0;
      end
      r[7*d +: 7] = ~l;
    end
    return r;
  endfunction

  function automatic logic [7:0] model_read(input int a);
    if (a < ND) return m_digit[a];
    if (a == 'h10) begin
`ifdef HEX_SCROLL_EN
      return {m_done, 3'b000, m_wrap, m_scroll, m_blink, m_en};
`else
      return {6'b0, m_blink, m_en};
`endif
    end
    if (a == 'h11) return m_mask;
`ifdef HEX_SCROLL_EN
    if (a == 'h12) return 8'(m_len);
    if (a >= 'h20 && a < 'h20 + MD) return m_msg[a - 'h20];
`endif
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    int a;
    if (reset) begin
      for (int i = 0; i < ND; i++) m_digit[i] = '0;
      for (int i = 0; i < MD; i++) m_msg[i] = '0;
      m_mask = '0; m_en = 0; m_blink = 0; m_scroll = 0; m_wrap = 0; m_done = 0; m_phase = 0;
      m_len = 1; m_pos = 0; m_edges = 0;
      exp_seg = ALL_BLANK;
      exp_rd = '0;
    end else begin
      exp_seg = model_seg();
      a = int'(bus.address);
      if (bus.read) exp_rd = model_read(a);
      m_edges++;
      if (m_edges % TD == 0) begin
        m_phase = ~m_phase;
`ifdef HEX_SCROLL_EN
        if (m_en && m_scroll) begin
          if (m_wrap) m_pos = (m_pos + 1 >= m_len) ? 0 : m_pos + 1;
          else if (m_pos < m_len) begin
            m_pos++;
            if (m_pos == m_len) m_done = 1;
          end
        end
`endif
      end
      if (bus.write) begin
        if (a < ND) m_digit[a] = bus.writedata;
        if (a == 'h10) begin
`ifdef HEX_SCROLL_EN
          if (bus.writedata[2] && !m_scroll) m_pos = 0;
          m_scroll = bus.writedata[2];
          m_wrap = bus.writedata[3];
          m_done = 0;
`endif
          m_en = bus.writedata[0];
          m_blink = bus.writedata[1];
        end
        if (a == 'h11) m_mask = bus.writedata;
`ifdef HEX_SCROLL_EN
        if (a == 'h12) begin
          m_len = (bus.writedata == 0) ? 1 : (int'(bus.writedata) > MD ? MD : int'(bus.writedata));
          m_pos = 0;
        end
        if (a >= 'h20 && a < 'h20 + MD) m_msg[a - 'h20] = bus.writedata;
`endif
      end
    end
  end

  task automatic drive_write(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic drive_read(input logic [5:0] a);
    @(negedge clk);
    bus.address = a; bus.read = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (seg !== ALL_BLANK) begin errors++; $display("[TB] FAIL reset_seg got %h expected %h", seg, ALL_BLANK); end
    checks++; if (bus.readdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_readdata got %h expected 00", bus.readdata); end
    drive_read(6'h10);
    checks++; if (bus.readdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_ctrl got %h expected 00", bus.readdata); end
  endtask

  task automatic test_hex_raw();
    drive_write(6'h00, 8'h05);
    drive_write(6'h01, 8'hC9);
    drive_write(6'h10, 8'h01);
    @(negedge clk);
    checks++; if (seg[6:0] !== ~7'h6D) begin errors++; $display("[TB] FAIL hex5 got %h expected %h", seg[6:0], ~7'h6D); end
    checks++; if (seg[13:7] !== ~7'h49) begin errors++; $display("[TB] FAIL raw49 got %h expected %h", seg[13:7], ~7'h49); end
    for (int d = 2; d < ND; d++) begin
      checks++;
      if (seg[7*d +: 7] !== ~7'h3F) begin errors++; $display("[TB] FAIL zero_digit%0d got %h expected %h", d, seg[7*d +: 7], ~7'h3F); end
    end
    checks++; if (seg !== exp_seg) begin errors++; $display("[TB] FAIL hex_raw_model got %h expected %h", seg, exp_seg); end
  endtask

  task automatic test_blink();
    int blank_cnt = 0;
    drive_write(6'h11, 8'h02);
    drive_write(6'h10, 8'h03);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      checks++; if (seg !== exp_seg) begin errors++; $display("[TB] FAIL blink_model got %h expected %h", seg, exp_seg); end
      checks++; if (seg[6:0] !== ~7'h6D) begin errors++; $display("[TB] FAIL blink_steady got %h expected %h", seg[6:0], ~7'h6D); end
      if (seg[13:7] === 7'h7F) blank_cnt++;
    end
    checks++; if (blank_cnt != 12) begin errors++; $display("[TB] FAIL blink_duty got %0d expected 12", blank_cnt); end
    drive_write(6'h10, 8'h01);
  endtask

  task automatic test_rw_same();
    drive_write(6'h02, 8'h11);
    @(negedge clk);
    bus.address = 6'h02; bus.writedata = 8'h22; bus.write = 1'b1; bus.read = 1'b1;
    @(negedge clk);
    bus.write = 1'b0; bus.read = 1'b0;
    checks++; if (bus.readdata !== 8'h11) begin errors++; $display("[TB] FAIL rw_same_old got %h expected 11", bus.readdata); end
    drive_read(6'h02);
    checks++; if (bus.readdata !== 8'h22) begin errors++; $display("[TB] FAIL rw_same_new got %h expected 22", bus.readdata); end
  endtask

  task automatic test_unmapped();
    logic [7:0] ctrl_exp;
    drive_write(6'h13, 8'hAA);
    drive_write(6'h06, 8'h55);
    drive_read(6'h01);
    drive_read(6'h13);
    checks++; if (bus.readdata !== 8'h00) begin errors++; $display("[TB] FAIL unmapped_13 got %h expected 00", bus.readdata); end
    drive_read(6'h01);
    drive_read(6'h06);
    checks++; if (bus.readdata !== 8'h00) begin errors++; $display("[TB] FAIL unmapped_06 got %h expected 00", bus.readdata); end
`ifndef HEX_SCROLL_EN
    drive_write(6'h12, 8'h05);
    drive_write(6'h20, 8'h33);
    drive_read(6'h01);
    drive_read(6'h12);
    checks++; if (bus.readdata !== 8'h00) begin errors++; $display("[TB] FAIL unmapped_len got %h expected 00", bus.readdata); end
    drive_read(6'h01);
    drive_read(6'h20);
    checks++; if (bus.readdata !== 8'h00) begin errors++; $display("[TB] FAIL unmapped_msg got %h expected 00", bus.readdata); end
    ctrl_exp = 8'h03;
`else
    ctrl_exp = 8'h0F;
`endif
    drive_write(6'h10, 8'hFF);
    drive_read(6'h10);
    checks++; if (bus.readdata !== ctrl_exp) begin errors++; $display("[TB] FAIL ctrl_bits got %h expected %h", bus.readdata, ctrl_exp); end
    drive_write(6'h10, 8'h01);
    @(negedge clk);
    checks++; if (seg !== exp_seg) begin errors++; $display("[TB] FAIL unmapped_seg got %h expected %h", seg, exp_seg); end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++; if (seg !== exp_seg) begin errors++; $display("[TB] FAIL random_seg cycle %0d got %h expected %h", i, seg, exp_seg); end
      checks++; if (bus.readdata !== exp_rd) begin errors++; $display("[TB] FAIL random_rd cycle %0d got %h expected %h", i, bus.readdata, exp_rd); end
      bus.write = ($urandom_range(0, 2) == 0);
      bus.read = ($urandom_range(0, 2) == 0);
      bus.writedata = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 6))
        0, 1: bus.address = 6'($urandom_range(0, 7));
        2: begin bus.address = 6'h10; if ($urandom_range(0, 3) != 0) bus.writedata[0] = 1'b1; end
        3: bus.address = 6'h11;
        4: begin bus.address = 6'h12; bus.writedata = 8'($urandom_range(0, 20)); end
        5: bus.address = 6'(8'h20 + 8'($urandom_range(0, 15)));
        default: bus.address = 6'($urandom_range(0, 63));
      endcase
    end
    @(negedge clk);
    bus.write = 1'b0; bus.read = 1'b0;
  endtask

`ifdef HEX_SCROLL_EN
  task automatic load_message();
    drive_write(6'h12, 8'h08);
    for (int i = 0; i < 8; i++) drive_write(6'(8'h20 + 8'(i)), 8'(i));
  endtask

  task automatic test_scroll_wrap();
    int e = 0;
    int steps = 0;
    logic [6:0] left;
    do_reset();
    load_message();
    drive_write(6'h10, 8'h0D);
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      left = seg[7*ND-1 -: 7];
      checks++; if (seg !== exp_seg) begin errors++; $display("[TB] FAIL wrap_model got %h expected %h", seg, exp_seg); end
      if (left !== ~GLYPH[e]) begin
        e = (e + 1) % 8;
        steps++;
        checks++; if (left !== ~GLYPH[e]) begin errors++; $display("[TB] FAIL wrap_left got %h expected %h", left, ~GLYPH[e]); end
      end
    end
    checks++; if (steps < 9) begin errors++; $display("[TB] FAIL wrap_steps got %0d expected >=9", steps); end
    drive_read(6'h10);
    checks++; if (bus.readdata !== 8'h0D) begin errors++; $display("[TB] FAIL wrap_done got %h expected 0d", bus.readdata); end
  endtask

  task automatic test_scroll_nowrap();
    do_reset();
    load_message();
    drive_write(6'h10, 8'h05);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++; if (seg !== exp_seg) begin errors++; $display("[TB] FAIL nowrap_model got %h expected %h", seg, exp_seg); end
    end
    checks++; if (seg !== ALL_BLANK) begin errors++; $display("[TB] FAIL nowrap_blank got %h expected %h", seg, ALL_BLANK); end
    drive_read(6'h10);
    checks++; if (bus.readdata !== 8'h85) begin errors++; $display("[TB] FAIL nowrap_done got %h expected 85", bus.readdata); end
    drive_write(6'h10, 8'h05);
    drive_read(6'h10);
    checks++; if (bus.readdata !== 8'h05) begin errors++; $display("[TB] FAIL done_clear got %h expected 05", bus.readdata); end
    checks++; if (seg !== ALL_BLANK) begin errors++; $display("[TB] FAIL nowrap_hold got %h expected %h", seg, ALL_BLANK); end
  endtask

  task automatic test_len();
    drive_write(6'h12, 8'h00);
    drive_read(6'h12);
    checks++; if (bus.readdata !== 8'h01) begin errors++; $display("[TB] FAIL len_min got %h expected 01", bus.readdata); end
    drive_write(6'h12, 8'hFF);
    drive_read(6'h12);
    checks++; if (bus.readdata !== 8'h10) begin errors++; $display("[TB] FAIL len_max got %h expected 10", bus.readdata); end
    drive_write(6'h12, 8'h08);
    drive_write(6'h10, 8'h0D);
    repeat (10) @(negedge clk);
    for (int i = 0; i < TD; i++) begin
      if (((m_edges + 1) % TD) == 0) break;
      @(negedge clk);
    end
    bus.address = 6'h12; bus.writedata = 8'h08; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
    @(negedge clk);
    checks++; if (seg[7*ND-1 -: 7] !== ~7'h3F) begin errors++; $display("[TB] FAIL len_tick got %h expected %h", seg[7*ND-1 -: 7], ~7'h3F); end
    checks++; if (seg !== exp_seg) begin errors++; $display("[TB] FAIL len_tick_model got %h expected %h", seg, exp_seg); end
  endtask
`endif

  task automatic test_reset_mid();
    drive_write(6'h11, 8'hFF);
`ifdef HEX_SCROLL_EN
    drive_write(6'h12, 8'h05);
    drive_write(6'h10, 8'h07);
`else
    drive_write(6'h10, 8'h03);
`endif
    drive_read(6'h11);
    repeat (6) @(negedge clk);
    do_reset();
    checks++; if (seg !== ALL_BLANK) begin errors++; $display("[TB] FAIL midreset_seg got %h expected %h", seg, ALL_BLANK); end
    checks++; if (bus.readdata !== 8'h00) begin errors++; $display("[TB] FAIL midreset_rd got %h expected 00", bus.readdata); end
    drive_read(6'h10);
    checks++; if (bus.readdata !== 8'h00) begin errors++; $display("[TB] FAIL midreset_ctrl got %h expected 00", bus.readdata); end
    drive_read(6'h11);
    checks++; if (bus.readdata !== 8'h00) begin errors++; $display("[TB] FAIL midreset_mask got %h expected 00", bus.readdata); end
`ifdef HEX_SCROLL_EN
    drive_read(6'h12);
    checks++; if (bus.readdata !== 8'h01) begin errors++; $display("[TB] FAIL midreset_len got %h expected 01", bus.readdata); end
`endif
    checks++; if (seg !== ALL_BLANK) begin errors++; $display("[TB] FAIL midreset_hold got %h expected %h", seg, ALL_BLANK); end
  endtask

  initial begin
    reset = 1'b1;
    bus.address = '0; bus.write = 1'b0; bus.writedata = '0; bus.read = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_hex_raw();
    test_blink();
    test_rw_same();
    test_unmapped();
    test_random(300);
`ifdef HEX_SCROLL_EN
    test_scroll_wrap();
    test_scroll_nowrap();
    test_len();
    test_random(300);
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Parametrised seven-segment display controller replacing direct register-to-HEX wiring in the computer top levels. It holds per-digit registers, either hex-decoded nibbles or raw segment patterns, behind a simple register bus. It drives all digits with a prescaled blink function and an optional scrolling message buffer. It sits between the system interconnect and the board's HEX pins, one instance per display group.

## Interface
- NUM_DIGITS, 6, number of digits driven (1..8)
- MSG_DEPTH, 16, scroll message buffer entries (2..16)
- TICK_DIV, 5000000, clk cycles per blink/scroll tick (≥2)
- ACTIVE_LOW, 1, 1 = segment lit when output bit is 0
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  6  register address
- write  in  1  write strobe, single cycle
- writedata  in  8  write data
- read  in  1  read strobe
- readdata  out  8  read data, valid 1 cycle after read
- seg  out  7*NUM_DIGITS  segments, digit d at [7d+6:7d], bit order g..a

## Operation
- Entry format, shared by digit and message registers: bit7=1 selects raw mode, bits6:0 are segments. Bit7=0 selects hex mode, bits3:0 are decoded 0-F as standard glyphs. Blank means all segments off.
- Address map:
  - 0x00+d: digit d (d<NUM_DIGITS)
  - 0x10: CTRL. bit0 EN, bit1 BLINK, bit2 SCROLL, bit3 WRAP, bit7 DONE (read-only, sticky)
  - 0x11: blink mask, bit d = digit d
  - 0x12: scroll length LEN
  - 0x20+i: message entry i (i<MSG_DEPTH)
  - Writes to unmapped addresses are ignored. Reads of unmapped addresses return 0.
- LEN write is clamped to 1..MSG_DEPTH. Its reset value is 1.
- Prescaler counts 0..TICK_DIV-1 and emits a 1-cycle tick on wrap. Each tick toggles blink phase.
- Display source precedence, applied per digit:
  - EN=0: blank.
  - SCROLL=1: digit d shows entry k = pos + (NUM_DIGITS-1-d).
    - WRAP=1: k is taken modulo LEN.
    - WRAP=0: k≥LEN shows blank.
  - Otherwise: digit register d.
  - Then, if BLINK=1, phase=1 and mask[d]=1, the digit is blanked.
- Scroll pointer pos:
  - Cleared on reset, on any LEN write, and on a CTRL write that sets SCROLL from 0 to 1.
  - Increments on each tick while EN and SCROLL are set.
  - WRAP=1: LEN-1 wraps to 0.
  - WRAP=0: pos advances to LEN, then holds; DONE is set when pos reaches LEN.
- DONE is cleared by any CTRL write.
- ACTIVE_LOW=1 inverts the final seg vector.

## Timing
- Reset: all registers 0, LEN=1, pos=0, phase=0, prescaler=0, readdata=0. seg is all blank, which is all ones when ACTIVE_LOW=1.
- seg is registered. A write sampled at edge E appears on seg after edge E+1.
- A tick at edge E (prescaler wrap) changes phase and pos at E. seg reflects the change after E+1.
- Read: read sampled at edge E; readdata is valid after E and held until the next read.
- Simultaneous LEN write and tick: the write wins and pos=0.
- Simultaneous CTRL write and DONE set: the write wins and DONE=0.
- read and write at the same address in one cycle: readdata returns the pre-write value.
- reset asserted mid-scroll: everything returns to reset values on that edge, with no partial state.

## Configuration
- HEX_SCROLL_EN defined: the message buffer, pos, WRAP, DONE and the scroll path are built as described.
- Undefined:
  - No message buffer or pointer logic is built.
  - CTRL bits 2, 3 and 7 read 0 and ignore writes.
  - 0x12 and 0x20-0x2F behave as unmapped.
  - The display always uses digit registers.

## Test plan
- Reset with ACTIVE_LOW=1, NUM_DIGITS=6 -> seg=42'h3FF_FFFF_FFFF. readdata=0, and CTRL read gives 0x00.
- Write digit0=0x05, digit1=0xC9 (raw 0x49), CTRL=0x01 -> after 2 edges, digit0 shows hex "5" glyph 0x6D inverted, and digit1 shows ~0x49. Other digits show ~0x3F ("0").
- TICK_DIV=4, BLINK=1, mask=0x02 -> digit1 blanks on every other 4-cycle tick window. digit0 is steady.
- HEX_SCROLL_EN, TICK_DIV=4, LEN=8, entries 0..7 = 0x00..0x07, CTRL=0x0D (WRAP) -> leftmost digit shows 0,1,..7,0 on successive ticks. DONE stays 0.
- Same setup with CTRL=0x05 (no WRAP) -> after 8 ticks all digits are blank and CTRL reads bit7=1. A write to CTRL=0x05 clears DONE, restarts nothing (SCROLL already 1), and the display holds blank.
- LEN write of 0 -> reads back 1. LEN write coinciding with a tick -> pos=0 on the next display.
